// File: rtl/pipe_pkg.sv
// Shared opcode, field-width and instruction-layout definitions for the
// four-stage issue pipeline.
package pipe_pkg;
    localparam int REG_W   = 4;
    localparam int ADDR_W  = 8;
    localparam int FUNC_W  = 3;
    localparam int INSTR_W = FUNC_W + 3 * REG_W + ADDR_W;

    localparam logic [FUNC_W-1:0] ADD = 3'b000;
    localparam logic [FUNC_W-1:0] SUB = 3'b001;
    localparam logic [FUNC_W-1:0] DIV = 3'b010;
    localparam logic [FUNC_W-1:0] MUL = 3'b011;
    localparam logic [FUNC_W-1:0] RSH = 3'b100;
    localparam logic [FUNC_W-1:0] LSH = 3'b101;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    // Shifts are single-source: their rs1 field is ignored by the datapath.
    function automatic logic uses_rs1(input logic [FUNC_W-1:0] func);
        return (func == ADD) || (func == SUB) || (func == DIV) || (func == MUL);
    endfunction

    function automatic logic is_legal(input logic [FUNC_W-1:0] func);
        return func <= LSH;
    endfunction
endpackage

// File: rtl/pipe_issue_fifo.sv
// Synchronous FIFO with full/empty flags; pointers carry one extra wrap bit
// so that full and empty are distinguishable.
module pipe_issue_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue/hazard controller: queues instructions, issues one per cycle unless a
// RAW hazard against S1/S2 exists, and shifts them through RF->EX->WB->MEM.
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_func,
    input  logic [3:0]        in_rs1,
    input  logic [3:0]        in_rs2,
    input  logic [3:0]        in_rd,
    input  logic [7:0]        in_addr,
    input  logic              flush,
    output logic              rd_en,
    output logic [3:0]        rd_rs1,
    output logic [3:0]        rd_rs2,
    output logic              ex_en,
    output logic [2:0]        ex_func,
    output logic              wb_en,
    output logic [3:0]        wb_rd,
    output logic              mem_en,
    output logic [7:0]        mem_addr,
    output logic              busy,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);
    instr_t in_instr;
    instr_t head;
    logic   q_full, q_empty, push, pop;
    logic   rs1_hit, rs2_hit, hazard, active, issue, drop, stall;

    logic              s1_v, s2_v, s3_v, s4_v;
    logic [REG_W-1:0]  s1_rs1, s1_rs2, s1_rd, s2_rd, s3_rd;
    logic [FUNC_W-1:0] s1_func, s2_func;
    logic [ADDR_W-1:0] s1_addr, s2_addr, s3_addr, s4_addr;

    // Handshake: a word transfers on any edge where in_valid && in_ready;
    // in_ready is !full only, so a full queue never accepts even while popping.
    assign in_instr = '{func: in_func, rs1: in_rs1, rs2: in_rs2, rd: in_rd, addr: in_addr};
    assign in_ready = !q_full;
    assign push     = in_valid && in_ready && !flush;

    pipe_issue_fifo #(.WIDTH(INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (in_instr),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty)
    );

    // S3 is excluded: its writeback lands on the same edge the head enters S1.
    assign rs1_hit = (s1_v && head.rs1 == s1_rd) || (s2_v && head.rs1 == s2_rd);
    assign rs2_hit = (s1_v && head.rs2 == s1_rd) || (s2_v && head.rs2 == s2_rd);
    assign hazard  = (uses_rs1(head.func) && rs1_hit) || rs2_hit;
    assign active  = !q_empty && !flush;
    assign issue   = active && is_legal(head.func) && !hazard;
    assign drop    = active && !is_legal(head.func);
    assign stall   = active && is_legal(head.func) && hazard;
    assign pop     = issue || drop;

    assign rd_en    = s1_v;
    assign rd_rs1   = s1_rs1;
    assign rd_rs2   = s1_rs2;
    assign ex_en    = s2_v;
    assign ex_func  = s2_func;
    assign wb_en    = s3_v;
    assign wb_rd    = s3_rd;
    assign mem_en   = s4_v;
    assign mem_addr = s4_addr;
    assign busy     = !q_empty || s1_v || s2_v || s3_v || s4_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s1_v, s2_v, s3_v, s4_v} <= '0;
            {s1_rs1, s1_rs2, s1_rd, s2_rd, s3_rd} <= '0;
            {s1_func, s2_func} <= '0;
            {s1_addr, s2_addr, s3_addr, s4_addr} <= '0;
            illegal_op <= 1'b0;
            issue_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            s1_v <= issue;
            s2_v <= s1_v;
            s3_v <= s2_v;
            s4_v <= s3_v;
            if (issue) begin
                s1_rs1  <= head.rs1;
                s1_rs2  <= head.rs2;
                s1_rd   <= head.rd;
                s1_func <= head.func;
                s1_addr <= head.addr;
            end
            if (s1_v) begin
                s2_func <= s1_func;
                s2_rd   <= s1_rd;
                s2_addr <= s1_addr;
            end
            if (s2_v) begin
                s3_rd   <= s2_rd;
                s3_addr <= s2_addr;
            end
            if (s3_v) s4_addr <= s3_addr;
            illegal_op <= drop;
            if (issue && issue_cnt != '1) issue_cnt <= issue_cnt + CNT_W'(1);
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Randomised and directed bench for pipe_issue_ctrl against a queue-based
// reference model of the issue rules.
module tb_pipe_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct {
        int func;
        int rs1;
        int rs2;
        int rd;
        int addr;
    } tb_instr_t;

    typedef struct {
        bit        v;
        tb_instr_t ins;
    } tb_slot_t;

    logic          clk, rst, in_valid, in_ready, flush;
    logic [2:0]    in_func, ex_func;
    logic [3:0]    in_rs1, in_rs2, in_rd, rd_rs1, rd_rs2, wb_rd;
    logic [7:0]    in_addr, mem_addr;
    logic          rd_en, ex_en, wb_en, mem_en, busy, illegal_op;
    logic [CW-1:0] issue_cnt, stall_cnt;

    pipe_issue_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_func    (in_func),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_addr    (in_addr),
        .flush      (flush),
        .rd_en      (rd_en),
        .rd_rs1     (rd_rs1),
        .rd_rs2     (rd_rs2),
        .ex_en      (ex_en),
        .ex_func    (ex_func),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .busy       (busy),
        .illegal_op (illegal_op),
        .issue_cnt  (issue_cnt),
        .stall_cnt  (stall_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ill_pulses;

    // Reference model: pending instruction queue plus the last four issue slots
    // (m_pipe[k] is what occupies stage k+1 after the most recent edge).
    tb_instr_t m_q[$];
    tb_slot_t  m_pipe[$];
    int        m_issue, m_stall;
    bit        m_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic tb_instr_t mk(input int f, input int a, input int b, input int d, input int ad);
        tb_instr_t t;
        t.func = f; t.rs1 = a; t.rs2 = b; t.rd = d; t.addr = ad;
        return t;
    endfunction

    function automatic bit tb_legal(input int f);
        return f <= 5;
    endfunction

    function automatic bit tb_reads_rs1(input int f);
        return f <= 3;
    endfunction

    // A source is blocked while its producer is still within two slots of issue.
    function automatic bit raw_blocked(input tb_instr_t h);
        for (int k = 0; k < 2; k++) begin
            if (m_pipe[k].v) begin
                if (h.rs2 == m_pipe[k].ins.rd) return 1'b1;
                if (tb_reads_rs1(h.func) && h.rs1 == m_pipe[k].ins.rd) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        tb_slot_t empty_slot;
        empty_slot.v = 1'b0;
        empty_slot.ins = mk(0, 0, 0, 0, 0);
        m_q.delete();
        m_pipe.delete();
        for (int k = 0; k < 4; k++) m_pipe.push_back(empty_slot);
        m_issue = 0;
        m_stall = 0;
        m_ill = 1'b0;
    endtask

    task automatic model_edge(input bit v, input tb_instr_t ins, input bit f);
        tb_slot_t slot;
        tb_instr_t h;
        bit acc;
        acc = v && (m_q.size() < DEPTH) && !f;
        slot.v = 1'b0;
        slot.ins = mk(0, 0, 0, 0, 0);
        m_ill = 1'b0;
        if (f) begin
            m_q.delete();
        end else if (m_q.size() > 0) begin
            h = m_q[0];
            if (!tb_legal(h.func)) begin
                void'(m_q.pop_front());
                m_ill = 1'b1;
            end else if (raw_blocked(h)) begin
                if (m_stall < CMAX) m_stall++;
            end else begin
                void'(m_q.pop_front());
                slot.v = 1'b1;
                slot.ins = h;
                if (m_issue < CMAX) m_issue++;
            end
        end
        if (acc) m_q.push_back(ins);
        m_pipe.push_front(slot);
        void'(m_pipe.pop_back());
    endtask

    task automatic check_outputs();
        bit any_v;
        any_v = m_pipe[0].v || m_pipe[1].v || m_pipe[2].v || m_pipe[3].v;
        check("rd_en", 32'(rd_en), 32'(m_pipe[0].v));
        if (m_pipe[0].v) begin
            check("rd_rs1", 32'(rd_rs1), m_pipe[0].ins.rs1);
            check("rd_rs2", 32'(rd_rs2), m_pipe[0].ins.rs2);
        end
        check("ex_en", 32'(ex_en), 32'(m_pipe[1].v));
        if (m_pipe[1].v) check("ex_func", 32'(ex_func), m_pipe[1].ins.func);
        check("wb_en", 32'(wb_en), 32'(m_pipe[2].v));
        if (m_pipe[2].v) check("wb_rd", 32'(wb_rd), m_pipe[2].ins.rd);
        check("mem_en", 32'(mem_en), 32'(m_pipe[3].v));
        if (m_pipe[3].v) check("mem_addr", 32'(mem_addr), m_pipe[3].ins.addr);
        check("illegal_op", 32'(illegal_op), 32'(m_ill));
        check("issue_cnt", 32'(issue_cnt), m_issue);
        check("stall_cnt", 32'(stall_cnt), m_stall);
        check("busy", 32'(busy), 32'((m_q.size() > 0) || any_v));
        if (illegal_op) ill_pulses++;
    endtask

    // Driver: called at a falling edge; applies inputs for the next rising edge.
    task automatic cycle(input bit v, input tb_instr_t ins, input bit f);
        in_valid = v;
        in_func  = 3'(ins.func);
        in_rs1   = 4'(ins.rs1);
        in_rs2   = 4'(ins.rs2);
        in_rd    = 4'(ins.rd);
        in_addr  = 8'(ins.addr);
        flush    = f;
        check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
        model_edge(v, ins, f);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, mk(0, 0, 0, 0, 0), 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_ex_en"}, 32'(ex_en), 0);
        check({tag, "_wb_en"}, 32'(wb_en), 0);
        check({tag, "_mem_en"}, 32'(mem_en), 0);
        check({tag, "_fields"}, 32'({rd_rs1, rd_rs2, ex_func, wb_rd, mem_addr}), 0);
        check({tag, "_issue_cnt"}, 32'(issue_cnt), 0);
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
        check({tag, "_illegal"}, 32'(illegal_op), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ill_pulses = 0;
        #1;
        check_reset_state("reset");
        check("reset_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        {in_func, in_rs1, in_rs2, in_rd, in_addr} = '0;

        // Independent stream: back-to-back issue, no stalls
        do_reset();
        cycle(1'b1, mk(0, 1, 2, 3, 8'h10), 1'b0);
        cycle(1'b1, mk(1, 4, 5, 6, 8'h20), 1'b0);
        cycle(1'b1, mk(3, 7, 8, 9, 8'h30), 1'b0);
        idle(6);
        check("indep_issue", 32'(issue_cnt), 3);
        check("indep_stall", 32'(stall_cnt), 0);

        // RAW at distance 1: two bubbles
        do_reset();
        cycle(1'b1, mk(0, 1, 2, 5, 8'h11), 1'b0);
        cycle(1'b1, mk(1, 5, 3, 6, 8'h22), 1'b0);
        idle(7);
        check("raw_stall", 32'(stall_cnt), 2);
        check("raw_issue", 32'(issue_cnt), 2);

        // Shift ignores rs1
        do_reset();
        cycle(1'b1, mk(0, 1, 2, 4, 8'h01), 1'b0);
        cycle(1'b1, mk(4, 4, 7, 8, 8'h02), 1'b0);
        idle(6);
        check("rsh_stall", 32'(stall_cnt), 0);

        // Illegal opcode between independent adds
        do_reset();
        cycle(1'b1, mk(0, 1, 2, 3, 8'h05), 1'b0);
        cycle(1'b1, mk(6, 1, 2, 3, 8'h06), 1'b0);
        cycle(1'b1, mk(0, 4, 5, 6, 8'h07), 1'b0);
        idle(6);
        check("ill_issue", 32'(issue_cnt), 2);
        check("ill_pulses", 32'(ill_pulses), 1);

        // Fill behind a dependency chain, then flush
        do_reset();
        cycle(1'b1, mk(0, 1, 2, 5, 8'h40), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, mk(1, 5, 5, 5, 8'h41 + i), 1'b0);
        check("full_in_ready", 32'(in_ready), 0);
        cycle(1'b1, mk(0, 1, 1, 1, 8'h50), 1'b1);
        check("flush_in_ready", 32'(in_ready), 1);
        idle(6);

        // Async reset with work in S2/S3
        do_reset();
        cycle(1'b1, mk(0, 1, 2, 3, 8'h60), 1'b0);
        cycle(1'b1, mk(0, 4, 5, 6, 8'h61), 1'b0);
        idle(2);
        rst = 1'b1;
        #1;
        check_reset_state("async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_state("post_rst");
        idle(3);

        // Random traffic with a small register set to provoke hazards
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 255)),
                  $urandom_range(0, 39) == 0);
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_issue_ctrl.md
Name: pipe_issue_ctrl

Overview:
- Issue/hazard controller for the team's 4-stage register-file/ALU pipeline (RF read -> EX -> RF writeback -> memory store).
- Buffers incoming instructions in a small FIFO and issues at most one per cycle.
- Tracks in-flight instructions in a 4-entry stage scoreboard, stalls issue on read-after-write hazards, and drives per-stage enables and addresses to the datapath.

Parameters:
- FIFO_DEPTH, 4, instruction queue entries; power of 2, minimum 2.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  queue can accept; transfer occurs when in_valid && in_ready.
- in_func  in  3  opcode: 000 add, 001 sub, 010 div, 011 mul, 100 rsh, 101 lsh; 110/111 illegal.
- in_rs1, in_rs2, in_rd  in  4 each  register indices.
- in_addr  in  8  memory store address.
- flush  in  1  synchronous; empties the queue.
- rd_en  out  1  S1 valid: datapath reads Reg[rd_rs1] and Reg[rd_rs2].
- rd_rs1, rd_rs2  out  4 each  S1 source indices.
- ex_en  out  1  S2 valid.
- ex_func  out  3  S2 opcode.
- wb_en  out  1  S3 valid: Reg[wb_rd] written at the end of this cycle.
- wb_rd  out  4  S3 destination.
- mem_en  out  1  S4 valid: mem[mem_addr] written at the end of this cycle.
- mem_addr  out  8  S4 store address.
- busy  out  1  queue non-empty or any stage valid.
- illegal_op  out  1  one-cycle pulse when an illegal opcode is dropped.
- issue_cnt  out  CNT_W  instructions issued, saturating.
- stall_cnt  out  CNT_W  hazard-stall cycles, saturating.

Behaviour:
- Reset: queue empty, all stage valids 0, all address/func outputs 0, counters 0, illegal_op 0. in_ready = 1 as soon as rst deasserts. A reset mid-operation discards everything in the queue and pipeline.
- Queue: FIFO of {func, rs1, rs2, rd, addr}, 23 bits.
  - in_ready = !full.
  - Simultaneous push and pop when full is not allowed; in_ready is low in that case.
  - Pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
- Source usage:
  - add/sub/div/mul use rs1 and rs2.
  - rsh/lsh use rs2 only; rs1 is never a hazard for them.
- Hazard rule: the head instruction stalls if any source it uses equals the rd of a valid instruction in S1 or S2.
  - S3 does not cause a hazard: its write commits on the same edge the head enters S1.
  - Maximum stall is 2 cycles per dependency.
- Issue: on a clock edge, if the queue is non-empty, there is no hazard, and head func is legal:
  - the head pops into S1;
  - issue_cnt increments.
  - Issue latency: an instruction accepted into an empty queue with no hazard appears in S1 (rd_en = 1) one cycle after acceptance.
- Illegal head (110/111):
  - pops without entering S1, so a bubble is inserted;
  - illegal_op pulses high the following cycle;
  - not counted in issue_cnt.
- Stall accounting: each edge on which a legal head is blocked by a hazard increments stall_cnt and inserts a bubble into S1.
- Stage advance is unconditional every cycle: S1->S2->S3->S4->retire. The pipeline itself never stalls.
- Stage outputs:
  - Each stage register carries its valid bit and the fields it needs.
  - Outputs are driven directly from the stage registers.
  - Field values are don't-care when the stage is invalid; the implementation holds the last value.
- flush:
  - Empties the queue on that edge; no pop or issue occurs that edge.
  - A push on the flush edge is discarded.
  - In-flight stages drain normally.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Shared package pipe_pkg:
  - opcode localparams (ADD..LSH);
  - instruction field widths (REG_W = 4, ADDR_W = 8, FUNC_W = 3);
  - packed instruction width (23);
  - function uses_rs1(func).
- One natural sub-module: pipe_issue_fifo, a parameterised synchronous FIFO with full/empty flags, instantiated for the queue.
- Hazard compare, stage shift register and counters stay in the top.

Test Plan:
- Independent stream: push add(r1,r2->r3), sub(r4,r5->r6), mul(r7,r8->r9) on consecutive cycles -> rd_en high 3 consecutive cycles; wb_en for rd 3, 6, 9 appears 2 cycles after each issue; mem_en 3 cycles after each issue; stall_cnt = 0; issue_cnt = 3.
- RAW distance 1: add(r1,r2->r5) then sub(r5,r3->r6) -> sub enters S1 exactly 3 cycles after add (2 bubbles); stall_cnt = 2.
- rsh with rs1 matching a pending rd: add(->r4) then rsh(rs1=4, rs2=7 ->r8) -> no stall, issued back-to-back; stall_cnt = 0.
- Illegal opcode: push func = 110 between two independent adds -> illegal_op pulses once; bubble in S1 between the adds; issue_cnt = 2.
- Full/backpressure and flush: hold S1 hazard while pushing 5 instructions with FIFO_DEPTH = 4 -> in_ready low after 4th; then assert flush -> queue empty next cycle, in_ready = 1, in-flight stages still complete their wb_en/mem_en.
- Async reset mid-stream: assert rst while 2 instructions are in S2/S3 -> all stage enables and counters 0 immediately, without waiting for a clock edge; nothing issues until new pushes arrive after rst deasserts.
